router_1_out_arbiter: RTL

Output-port scheduler for router_1 in the 2x2 mesh. It shares one output port among the W, S and L input FIFOs using round-robin arbitration with wormhole packet locking. It drives the crossbar select lines and the input-FIFO read strobes, and it gates flit transfer on downstream credits. There is one instance per output port, placed between the input FIFOs and the crossbar.

---
 rtl/router_1_out_arbiter_if.sv | 31 +++
 rtl/router_1_out_arbiter.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/router_1_out_arbiter_if.sv
// Handshake bundle between one router_1 output-port arbiter and its input FIFOs,
// crossbar and downstream credit return.
interface router_1_out_arbiter_if #(
    parameter int unsigned CNT_W = 3
);
    logic             req_W;
    logic             req_S;
    logic             req_L;
    logic             tail_W;
    logic             tail_S;
    logic             tail_L;
    logic             credit_in;
    logic [2:0]       sel_out;
    logic             rd_W;
    logic             rd_S;
    logic             rd_L;
    logic             flit_valid;
    logic [CNT_W-1:0] credit_cnt;
    logic             busy;
    logic             wdog_err;

    modport master (
        input  req_W, req_S, req_L, tail_W, tail_S, tail_L, credit_in,
        output sel_out, rd_W, rd_S, rd_L, flit_valid, credit_cnt, busy, wdog_err
    );

    modport slave (
        output req_W, req_S, req_L, tail_W, tail_S, tail_L, credit_in,
        input  sel_out, rd_W, rd_S, rd_L, flit_valid, credit_cnt, busy, wdog_err
    );
endinterface

// File: rtl/router_1_out_arbiter.sv
// Round-robin wormhole arbiter sharing one router_1 output among W/S/L FIFOs, credit-gated.
// Optional lock watchdog enabled by defining ROUTER1_ARB_WATCHDOG_EN.
module router_1_out_arbiter #(
    parameter int unsigned CREDITS     = 4,
    parameter int unsigned CNT_W       = 3,
    parameter int unsigned WDOG_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    router_1_out_arbiter_if.master bus
);
    // Crossbar port codes shared with router_1_state_defines.v
    localparam logic [2:0] W_PORT  = 3'd3;
    localparam logic [2:0] S_PORT  = 3'd2;
    localparam logic [2:0] L_PORT  = 3'd4;
    localparam logic [2:0] NO_PORT = 3'b111;
    localparam int unsigned SUM_W  = CNT_W + 1;

    typedef enum logic {IDLE, LOCKED} state_e;
    typedef enum logic [1:0] {PW = 2'd0, PS = 2'd1, PL = 2'd2} port_e;

    state_e           state_q, state_d;
    port_e            grant_q, grant_d, last_q, last_d, winner;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SUM_W-1:0] cnt_sum;
    logic             req_g, tail_g, xfer, wdog_fire, fv;
    logic [2:0]       rd, sel;

    if (CREDITS == 0 || CREDITS > (2 ** CNT_W) - 1) begin : g_bad_credits
        $error("CREDITS must be in 1..2^CNT_W-1");
    end
    if (WDOG_CYCLES == 0) begin : g_bad_wdog
        $error("WDOG_CYCLES must be nonzero");
    end

    // Head-of-line status of the granted FIFO
    always_comb begin
        req_g  = 1'b0;
        tail_g = 1'b0;
        case (grant_q)
            PW:      begin req_g = bus.req_W; tail_g = bus.tail_W; end
            PS:      begin req_g = bus.req_S; tail_g = bus.tail_S; end
            PL:      begin req_g = bus.req_L; tail_g = bus.tail_L; end
            default: begin req_g = 1'b0;      tail_g = 1'b0;      end
        endcase
    end

    assign xfer = (state_q == LOCKED) && req_g && (cnt_q != '0);

    // Round-robin pick, starting at the port after the last winner
    always_comb begin
        winner = PW;
        case (last_q)
            PW: begin
                if (bus.req_S)      winner = PS;
                else if (bus.req_L) winner = PL;
                else                winner = PW;
            end
            PS: begin
                if (bus.req_L)      winner = PL;
                else if (bus.req_W) winner = PW;
                else                winner = PS;
            end
            default: begin
                if (bus.req_W)      winner = PW;
                else if (bus.req_S) winner = PS;
                else                winner = PL;
            end
        endcase
    end

`ifdef ROUTER1_ARB_WATCHDOG_EN
    localparam int unsigned WD_W = $clog2(WDOG_CYCLES + 1);
    logic [WD_W-1:0] wdog_q;
    logic            wdog_err_q;

    // Counts stalled LOCKED cycles; cleared by any transfer or by leaving LOCKED
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog_q     <= '0;
            wdog_err_q <= 1'b0;
        end else begin
            wdog_err_q <= wdog_fire;
            if (state_q != LOCKED || xfer || wdog_fire) wdog_q <= '0;
            else                                        wdog_q <= wdog_q + WD_W'(1);
        end
    end

    assign bus.wdog_err = wdog_err_q;
`else
    assign bus.wdog_err = 1'b0;
`endif

    // Next-state and crossbar/FIFO strobes
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        sel       = NO_PORT;
        rd        = 3'b000;
        fv        = 1'b0;
        wdog_fire = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_W || bus.req_S || bus.req_L) begin
                    grant_d = winner;
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                case (grant_q)
                    PW:      sel = W_PORT;
                    PS:      sel = S_PORT;
                    PL:      sel = L_PORT;
                    default: sel = NO_PORT;
                endcase
                if (xfer) begin
                    rd = 3'b001 << grant_q;
                    fv = 1'b1;
                    if (tail_g) begin
                        state_d = IDLE;
                        last_d  = grant_q;
                    end
                end
`ifdef ROUTER1_ARB_WATCHDOG_EN
                else if (wdog_q == WD_W'(WDOG_CYCLES - 1)) begin
                    wdog_fire = 1'b1;
                    state_d   = IDLE;
                    last_d    = grant_q;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // Credit counter saturates at CREDITS; a return and a use in the same cycle cancel
    always_comb begin
        cnt_sum = {1'b0, cnt_q} + SUM_W'(bus.credit_in) - SUM_W'(xfer);
        cnt_d   = (cnt_sum > SUM_W'(CREDITS)) ? CNT_W'(CREDITS) : cnt_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= PW;
            last_q  <= PL;
            cnt_q   <= CNT_W'(CREDITS);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.sel_out    = sel;
    assign bus.rd_W       = rd[0];
    assign bus.rd_S       = rd[1];
    assign bus.rd_L       = rd[2];
    assign bus.flit_valid = fv;
    assign bus.credit_cnt = cnt_q;
    assign bus.busy       = (state_q == LOCKED);
endmodule
